// File: rtl/ram_io_port_adapter.sv
// In-order fabric-to-SRAM request adapter: 2-entry request FIFO, fixed-latency read return.
// Define RAM_IO_RDATA_REG_EN to add one output register stage on fab_rdata/fab_rvalid.
module ram_io_port_adapter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  UserCLK,
    input  logic                  Reset,
    input  logic                  fab_req,
    input  logic                  fab_we,
    input  logic [ADDR_W-1:0]     fab_addr,
    input  logic [DATA_W-1:0]     fab_wdata,
    input  logic [DATA_W/8-1:0]   fab_be,
    output logic                  fab_ready,
    output logic                  fab_rvalid,
    output logic [DATA_W-1:0]     fab_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    req_t              fifo_mem [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    state_t            state_reg;
    logic [2:0]        lat_cnt_reg;
    logic              cap_valid_reg;
    logic [DATA_W-1:0] cap_data_reg;

    logic              push;
    logic              avail;
    logic              rd_done;
    logic              issue;
    req_t              incoming;
    req_t              head;

    assign fab_ready = (count_reg < 2'd2);

    // An empty FIFO forwards the incoming request so ram_en rises the cycle after acceptance.
    always_comb begin
        incoming   = {fab_we, fab_addr, fab_wdata, fab_be};
        push       = fab_req && fab_ready;
        head       = (count_reg != 2'd0) ? fifo_mem[rd_ptr_reg] : incoming;
        avail      = (count_reg != 2'd0) || push;
        rd_done    = (state_reg == WAIT_RD) && (lat_cnt_reg == 3'd1);
        issue      = avail && ((state_reg == IDLE) ||
                               ((state_reg == ISSUE) && ram_we) ||
                               rd_done);
        count_next = count_reg + {1'b0, push} - {1'b0, issue};
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            state_reg     <= IDLE;
            lat_cnt_reg   <= 3'd0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_be        <= '0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            cap_valid_reg <= 1'b0;
            cap_data_reg  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= incoming;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (issue) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;

            if (issue) begin
                ram_en   <= 1'b1;
                ram_we   <= head.we;
                ram_be   <= head.we ? head.be : '0;
                ram_addr <= head.addr;
                if (head.we) begin
                    ram_wdata <= head.wdata;
                end
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                ram_be <= '0;
            end

            cap_valid_reg <= rd_done;
            if (rd_done) begin
                cap_data_reg <= ram_rdata;
            end

            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ram_we reflects the access being driven this cycle.
                    if (!ram_we) begin
                        state_reg   <= WAIT_RD;
                        lat_cnt_reg <= 3'(RD_LAT);
                    end else if (!issue) begin
                        state_reg <= IDLE;
                    end
                end
                WAIT_RD: begin
                    lat_cnt_reg <= lat_cnt_reg - 3'd1;
                    if (rd_done) begin
                        state_reg <= issue ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_IO_RDATA_REG_EN
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= cap_valid_reg;
            if (cap_valid_reg) begin
                out_data_reg <= cap_data_reg;
            end
        end
    end

    assign fab_rvalid = out_valid_reg;
    assign fab_rdata  = out_data_reg;
`else
    assign fab_rvalid = cap_valid_reg;
    assign fab_rdata  = cap_data_reg;
`endif

endmodule

// File: tb/tb_ram_io_port_adapter.sv
// Scoreboard bench for ram_io_port_adapter with a behavioural fixed-latency SRAM model.
// Honours RAM_IO_RDATA_REG_EN for the expected read-response latency.
module tb_ram_io_port_adapter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int BE_W   = DATA_W / 8;
`ifdef RAM_IO_RDATA_REG_EN
    localparam int RESP_LAT = RD_LAT + 3;
`else
    localparam int RESP_LAT = RD_LAT + 2;
`endif

    logic              UserCLK;
    logic              Reset;
    logic              fab_req;
    logic              fab_we;
    logic [ADDR_W-1:0] fab_addr;
    logic [DATA_W-1:0] fab_wdata;
    logic [BE_W-1:0]   fab_be;
    logic              fab_ready;
    logic              fab_rvalid;
    logic [DATA_W-1:0] fab_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    ram_io_port_adapter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .UserCLK   (UserCLK),
        .Reset     (Reset),
        .fab_req   (fab_req),
        .fab_we    (fab_we),
        .fab_addr  (fab_addr),
        .fab_wdata (fab_wdata),
        .fab_be    (fab_be),
        .fab_ready (fab_ready),
        .fab_rvalid(fab_rvalid),
        .fab_rdata (fab_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    // Behavioural macro: samples on the edge after ram_en, data usable RD_LAT edges later.
    logic [DATA_W-1:0] sram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge UserCLK) begin
        if (ram_en === 1'b1) begin
            if (ram_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (ram_be[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                rd_pipe[0] <= sram[ram_addr];
            end
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } acc_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        int                cyc;
    } rd_t;

    acc_t exp_ram [$];
    acc_t obs_ram [$];
    rd_t  exp_rd  [$];
    rd_t  obs_rd  [$];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   prev_rvalid = 0;
    int   en_run = 0;
    int   max_run = 0;
    int   idle_bad = 0;
    int   dbl_rvalid = 0;
    int   ready_low = 0;
    acc_t mon_acc;
    rd_t  mon_rd;

    always @(posedge UserCLK) cyc <= cyc + 1;

    always @(negedge UserCLK) begin
        if (mon_en) begin
            if (ram_en === 1'b1) begin
                mon_acc.we    = ram_we;
                mon_acc.addr  = ram_addr;
                mon_acc.wdata = ram_we ? ram_wdata : '0;
                mon_acc.be    = ram_we ? ram_be : '0;
                obs_ram.push_back(mon_acc);
                en_run++;
                if (en_run > max_run) max_run = en_run;
            end else begin
                en_run = 0;
                if (ram_we !== 1'b0 || ram_be !== '0) idle_bad++;
            end
            if (fab_rvalid === 1'b1) begin
                mon_rd.data = fab_rdata;
                mon_rd.cyc  = cyc;
                obs_rd.push_back(mon_rd);
                if (prev_rvalid) dbl_rvalid++;
            end
            prev_rvalid = (fab_rvalid === 1'b1);
            if (fab_ready !== 1'b1) ready_low++;
        end
    end

    task automatic clear_sb();
        exp_ram.delete();
        obs_ram.delete();
        exp_rd.delete();
        obs_rd.delete();
        ready_low = 0;
        max_run   = 0;
    endtask

    // Presents one request, holds it while fab_ready is low, and records expectations on acceptance.
    task automatic send(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                        input bit chk_lat);
        bit   done = 0;
        int   acc  = 0;
        acc_t a;
        rd_t  r;
        @(negedge UserCLK);
        fab_req = 1'b1; fab_we = we; fab_addr = addr; fab_wdata = wdata; fab_be = be;
        for (int k = 0; k < 50 && !done; k++) begin
            if (fab_ready === 1'b1) begin
                acc = cyc;
                @(posedge UserCLK);
                done = 1;
            end else begin
                @(negedge UserCLK);
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL accept_timeout addr=%h fab_ready=%b required=1", addr, fab_ready);
        end else begin
            a.we = we; a.addr = addr; a.wdata = we ? wdata : '0; a.be = we ? be : '0;
            exp_ram.push_back(a);
            if (we) begin
                for (int b = 0; b < BE_W; b++)
                    if (be[b]) shadow[addr][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                r.data = shadow[addr];
                r.cyc  = chk_lat ? acc + RESP_LAT : -1;
                exp_rd.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge UserCLK);
        fab_req = 1'b0;
        repeat (n) @(negedge UserCLK);
    endtask

    task automatic test_reset();
        Reset = 1'b1; fab_req = 1'b1; fab_we = 1'b0; fab_addr = 10'h003;
        fab_wdata = 32'h0; fab_be = 4'h0;
        @(negedge UserCLK);
        mon_en = 1;
        clear_sb();
        repeat (2) @(negedge UserCLK);
        Reset = 1'b0; fab_req = 1'b0;
        @(negedge UserCLK);
        checks++; if (fab_ready !== 1'b1)  begin failures++; $display("FAIL reset_fab_ready got=%b required=1", fab_ready); end
        checks++; if (fab_rvalid !== 1'b0) begin failures++; $display("FAIL reset_fab_rvalid got=%b required=0", fab_rvalid); end
        checks++; if (fab_rdata !== 32'h0) begin failures++; $display("FAIL reset_fab_rdata got=%h required=0", fab_rdata); end
        checks++; if (ram_en !== 1'b0)     begin failures++; $display("FAIL reset_ram_en got=%b required=0", ram_en); end
        checks++; if (ram_we !== 1'b0)     begin failures++; $display("FAIL reset_ram_we got=%b required=0", ram_we); end
        checks++; if (ram_be !== 4'h0)     begin failures++; $display("FAIL reset_ram_be got=%h required=0", ram_be); end
        checks++; if (ram_addr !== 10'h0)  begin failures++; $display("FAIL reset_ram_addr got=%h required=0", ram_addr); end
        checks++; if (ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram_wdata got=%h required=0", ram_wdata); end
        repeat (4) @(negedge UserCLK);
        checks++; if (obs_ram.size() != 0) begin failures++; $display("FAIL reset_no_ram_en got=%0d accesses required=0", obs_ram.size()); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_write_read();
        acc_t e, o;
        rd_t  er, orr;
        clear_sb();
        send(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0);
        send(1'b0, 10'h005, 32'h0, 4'h0, 1'b1);
        idle(12);
        checks++; if (obs_ram.size() != exp_ram.size()) begin failures++; $display("FAIL wr_rd_ram_count got=%0d required=%0d", obs_ram.size(), exp_ram.size()); end
        while (exp_ram.size() > 0 && obs_ram.size() > 0) begin
            e = exp_ram.pop_front(); o = obs_ram.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL wr_rd_ram_access got=%h required=%h", o, e); end
        end
        checks++; if (obs_rd.size() != 1) begin failures++; $display("FAIL wr_rd_rvalid_count got=%0d required=1", obs_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++; if (orr.data !== er.data) begin failures++; $display("FAIL wr_rd_rdata got=%h required=%h", orr.data, er.data); end
            if (er.cyc >= 0) begin
                checks++; if (orr.cyc !== er.cyc) begin failures++; $display("FAIL wr_rd_latency got_cycle=%0d required=%0d", orr.cyc, er.cyc); end
            end
        end
        checks++; if (fab_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_rdata_hold got=%h required=deadbeef", fab_rdata); end
        checks++; if (fab_rvalid !== 1'b0) begin failures++; $display("FAIL wr_rd_rvalid_low got=%b required=0", fab_rvalid); end
        $display("test_write_read done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_byte_enables();
        rd_t er, orr;
        clear_sb();
        send(1'b1, 10'h0A0, 32'h11223344, 4'hF, 1'b0);
        send(1'b1, 10'h0A0, 32'hAABBCCDD, 4'h5, 1'b0);
        send(1'b0, 10'h0A0, 32'h0, 4'h0, 1'b0);
        idle(12);
        checks++; if (obs_ram.size() != 3) begin failures++; $display("FAIL be_ram_count got=%0d required=3", obs_ram.size()); end
        checks++; if (obs_rd.size() != 1) begin failures++; $display("FAIL be_rvalid_count got=%0d required=1", obs_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++; if (orr.data !== er.data) begin failures++; $display("FAIL be_rdata got=%h required=%h", orr.data, er.data); end
        end
        $display("test_byte_enables done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_backpressure();
        acc_t e, o;
        rd_t  er, orr;
        clear_sb();
        send(1'b0, 10'h005, 32'h0, 4'h0, 1'b1);
        send(1'b1, 10'h010, 32'h01020304, 4'hF, 1'b0);
        send(1'b0, 10'h010, 32'h0, 4'h0, 1'b0);
        send(1'b0, 10'h005, 32'h0, 4'h0, 1'b0);
        idle(20);
        checks++; if (ready_low == 0) begin failures++; $display("FAIL bp_ready_drop got=%0d low cycles required>=1", ready_low); end
        checks++; if (obs_ram.size() != exp_ram.size()) begin failures++; $display("FAIL bp_ram_count got=%0d required=%0d", obs_ram.size(), exp_ram.size()); end
        while (exp_ram.size() > 0 && obs_ram.size() > 0) begin
            e = exp_ram.pop_front(); o = obs_ram.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL bp_ram_order got=%h required=%h", o, e); end
        end
        checks++; if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL bp_rvalid_count got=%0d required=%0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++; if (orr.data !== er.data) begin failures++; $display("FAIL bp_rdata got=%h required=%h", orr.data, er.data); end
            if (er.cyc >= 0) begin
                checks++; if (orr.cyc !== er.cyc) begin failures++; $display("FAIL bp_latency got_cycle=%0d required=%0d", orr.cyc, er.cyc); end
            end
        end
        $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_read();
        rd_t er, orr;
        clear_sb();
        send(1'b0, 10'h005, 32'h0, 4'h0, 1'b0);
        @(negedge UserCLK);
        fab_req = 1'b0;
        @(negedge UserCLK);
        Reset = 1'b1;
        @(negedge UserCLK);
        Reset = 1'b0;
        checks++; if (fab_rdata !== 32'h0) begin failures++; $display("FAIL mid_rst_rdata got=%h required=0", fab_rdata); end
        repeat (8) @(negedge UserCLK);
        checks++; if (obs_rd.size() != 0) begin failures++; $display("FAIL mid_rst_no_rvalid got=%0d required=0", obs_rd.size()); end
        exp_rd.delete();
        obs_rd.delete();
        send(1'b0, 10'h0A0, 32'h0, 4'h0, 1'b1);
        idle(12);
        checks++; if (obs_rd.size() != 1) begin failures++; $display("FAIL mid_rst_fresh_count got=%0d required=1", obs_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++; if (orr.data !== er.data) begin failures++; $display("FAIL mid_rst_fresh_rdata got=%h required=%h", orr.data, er.data); end
            checks++; if (orr.cyc !== er.cyc) begin failures++; $display("FAIL mid_rst_fresh_latency got_cycle=%0d required=%0d", orr.cyc, er.cyc); end
        end
        $display("test_reset_mid_read done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_write_burst();
        acc_t e, o;
        rd_t  er, orr;
        clear_sb();
        for (int i = 0; i < 8; i++) send(1'b1, 10'(10'h100 + i), $urandom, 4'hF, 1'b0);
        idle(3);
        checks++; if (max_run != 8) begin failures++; $display("FAIL burst_ram_en_run got=%0d required=8", max_run); end
        send(1'b0, 10'h103, 32'h0, 4'h0, 1'b1);
        idle(12);
        checks++; if (obs_ram.size() != 9) begin failures++; $display("FAIL burst_ram_count got=%0d required=9", obs_ram.size()); end
        while (exp_ram.size() > 0 && obs_ram.size() > 0) begin
            e = exp_ram.pop_front(); o = obs_ram.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL burst_ram_access got=%h required=%h", o, e); end
        end
        checks++; if (obs_rd.size() != 1) begin failures++; $display("FAIL burst_rvalid_count got=%0d required=1", obs_rd.size()); end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            er = exp_rd.pop_front(); orr = obs_rd.pop_front();
            checks++; if (orr.data !== er.data) begin failures++; $display("FAIL burst_rdata got=%h required=%h", orr.data, er.data); end
            checks++; if (orr.cyc !== er.cyc) begin failures++; $display("FAIL burst_latency got_cycle=%0d required=%0d", orr.cyc, er.cyc); end
        end
        $display("test_write_burst done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_invariants();
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL idle_ram_we_be got=%0d bad cycles required=0", idle_bad); end
        checks++; if (dbl_rvalid != 0) begin failures++; $display("FAIL rvalid_back_to_back got=%0d required=0", dbl_rvalid); end
        $display("test_invariants done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_backpressure();
        test_reset_mid_read();
        test_write_burst();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
